motor_driver_output_stage: RTL
==============================

Name: motor_driver_output_stage

Overview:
- Sits directly downstream of the backend cycle controller and consumes its row_select, col_select, output_active, inverter_select, row_col_select and update_cycle_complete.
- Holds the row and column pattern memories and looks up a direction bit per driver each cycle.
- Drives a complementary p/n pair per H-bridge channel, with programmable break-before-make dead time on every direction change.

Parameters:
MEM_ADDRESS_LENGTH, 7, address width of each pattern memory (2^N words)
NUM_OF_DRIVERS, 16, number of driver channels and width of a pattern word
DEAD_TIME_WIDTH, 4, width of the dead-time setting and per-channel counter

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
write_mem_n  input  1  active-low pattern memory write strobe
mem_select  input  1  write target: 0 = row memory, 1 = column memory
mem_address  input  MEM_ADDRESS_LENGTH  write address
mem_data  input  NUM_OF_DRIVERS  write data
dead_time  input  DEAD_TIME_WIDTH  dead-time setting in cycles, static during operation
row_select  input  MEM_ADDRESS_LENGTH  row memory read address from the cycle controller
col_select  input  MEM_ADDRESS_LENGTH  column memory read address from the cycle controller
output_active  input  1  drive window from the cycle controller
inverter_select  input  NUM_OF_DRIVERS  per-channel direction inversion
row_col_select  input  NUM_OF_DRIVERS  per-channel source: 0 = row word, 1 = column word
update_cycle_complete  input  1  sequence finished; forces all channels off
driver_p  output  NUM_OF_DRIVERS  forward-side drive
driver_n  output  NUM_OF_DRIVERS  reverse-side drive
drivers_busy  output  1  OR of all driver_p, driver_n and nonzero dead-time counters

Behaviour:
- Clock and reset: single clock domain. reset_n is asynchronous active-low.
- Reset values: driver_p = 0, driver_n = 0, drivers_busy = 0, all channel states OFF, counters 0, pipeline registers 0.
- Memory contents are not reset.
- Asserting reset_n low mid-operation drops all outputs in the same instant (asynchronously).
- Memories: two arrays, 2^MEM_ADDRESS_LENGTH x NUM_OF_DRIVERS each, with synchronous read.
- Write: on a clock edge with write_mem_n = 0, mem_data is written to mem_address in the memory chosen by mem_select.
- Read-during-write to the same address returns the old data. Writes are accepted at any time.
- Stage 1 (edge k+1): register row_word = row_mem[row_select] and col_word = col_mem[col_select].
- Stage 1 also registers active_d = output_active & !update_cycle_complete, so it aligns with the read data.
- Target per channel i: dir = (row_col_select[i] ? col_word[i] : row_word[i]) ^ inverter_select[i].
  - Target = OFF if !active_d or update_cycle_complete.
  - Otherwise target = FWD if dir = 1, REV if dir = 0.
- Channel FSM (one per channel, states OFF / FWD / REV, plus counter cnt):
  - FWD or REV, target equal to current state: hold.
  - FWD or REV, target different (OFF or the opposite direction): state <= OFF, cnt <= dead_time.
  - OFF, cnt != 0: cnt <= cnt - 1, stay OFF regardless of target.
  - OFF, cnt == 0, target != OFF: state <= target.
- Outputs are registered and decoded from state: driver_p[i] = (state == FWD), driver_n[i] = (state == REV).
- Invariant: driver_p[i] and driver_n[i] are never both 1, in any cycle, including across reset.
- Latency: a row/col address change or output_active edge at edge k appears on driver_p/n after edge k+2, when no dead time applies.
- A reversal holds both outputs low for dead_time + 1 cycles. dead_time = 0 still inserts one OFF cycle.
- Dropping to OFF also loads cnt, so a fast re-enable still honours the dead time.
- update_cycle_complete asserted forces every channel to OFF within one edge. Channels remain OFF while it stays high.
- dead_time changes take effect at the next counter load only.

Test Plan:
- Reset and idle: reset_n low, then release with output_active = 0 -> driver_p = driver_n = 0, drivers_busy = 0 indefinitely.
- Basic drive: write row_mem[3] = 16'h00FF with row_col_select = 0, inverter_select = 0, row_select = 3, output_active rising at edge k -> after edge k+2, driver_p = 16'h00FF and driver_n = 16'hFF00.
- Column select and inversion: col_mem[5] = 16'h0001, row_col_select = 16'h0001, inverter_select = 16'h0001, col_select = 5 -> channel 0 drives REV (driver_n[0] = 1, driver_p[0] = 0).
- Dead time: dead_time = 3, channel 0 in FWD, flip its pattern bit -> driver_p[0] = driver_n[0] = 0 for exactly 4 cycles, then driver_n[0] = 1. Repeat with dead_time = 0 -> exactly 1 OFF cycle.
- Sequence end: assert update_cycle_complete while all channels are driving -> all outputs 0 after one edge. drivers_busy clears dead_time + 1 cycles later.
- Async reset mid-drive, plus a random-stimulus run -> outputs go to 0 with no clock edge. Across 10k random cycles, driver_p & driver_n == 0 is asserted every cycle.

Source files
------------

// File: rtl/motor_driver_output_stage.sv
// H-bridge output stage: row/column pattern memories feed per-channel OFF/FWD/REV
// state machines that insert break-before-make dead time on every direction change.
module motor_driver_output_stage #(
    parameter int MEM_ADDRESS_LENGTH = 7,
    parameter int NUM_OF_DRIVERS     = 16,
    parameter int DEAD_TIME_WIDTH    = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          write_mem_n,
    input  logic                          mem_select,
    input  logic [MEM_ADDRESS_LENGTH-1:0] mem_address,
    input  logic [NUM_OF_DRIVERS-1:0]     mem_data,
    input  logic [DEAD_TIME_WIDTH-1:0]    dead_time,
    input  logic [MEM_ADDRESS_LENGTH-1:0] row_select,
    input  logic [MEM_ADDRESS_LENGTH-1:0] col_select,
    input  logic                          output_active,
    input  logic [NUM_OF_DRIVERS-1:0]     inverter_select,
    input  logic [NUM_OF_DRIVERS-1:0]     row_col_select,
    input  logic                          update_cycle_complete,
    output logic [NUM_OF_DRIVERS-1:0]     driver_p,
    output logic [NUM_OF_DRIVERS-1:0]     driver_n,
    output logic                          drivers_busy
);

    localparam int DEPTH = 1 << MEM_ADDRESS_LENGTH;

    // Encoding chosen so driver_p/driver_n come straight off state flops, glitch-free.
    typedef enum logic [1:0] {
        CH_OFF = 2'b00,
        CH_FWD = 2'b01,
        CH_REV = 2'b10
    } ch_state_t;

    logic [NUM_OF_DRIVERS-1:0]  row_mem [DEPTH];
    logic [NUM_OF_DRIVERS-1:0]  col_mem [DEPTH];

    logic [NUM_OF_DRIVERS-1:0]  row_word;
    logic [NUM_OF_DRIVERS-1:0]  col_word;
    logic                       active_d;
    logic [NUM_OF_DRIVERS-1:0]  dir;
    logic                       cnt_busy;

    ch_state_t                  target     [NUM_OF_DRIVERS];
    ch_state_t                  state      [NUM_OF_DRIVERS];
    ch_state_t                  state_next [NUM_OF_DRIVERS];
    logic [DEAD_TIME_WIDTH-1:0] cnt        [NUM_OF_DRIVERS];
    logic [DEAD_TIME_WIDTH-1:0] cnt_next   [NUM_OF_DRIVERS];

    always_ff @(posedge clock) begin
        if (!write_mem_n) begin
            if (mem_select) begin
                col_mem[mem_address] <= mem_data;
            end else begin
                row_mem[mem_address] <= mem_data;
            end
        end
    end

    // Read data and the gated drive window are registered together so they stay aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_word <= '0;
            col_word <= '0;
            active_d <= 1'b0;
        end else begin
            row_word <= row_mem[row_select];
            col_word <= col_mem[col_select];
            active_d <= output_active & ~update_cycle_complete;
        end
    end

    assign dir = ((row_col_select & col_word) | (~row_col_select & row_word)) ^ inverter_select;

    always_comb begin
        for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
            target[i] = CH_OFF;
            if (active_d && !update_cycle_complete) begin
                target[i] = dir[i] ? CH_FWD : CH_REV;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
                state[i] <= CH_OFF;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
        end
    end

    // Any departure from a driving state goes through OFF and reloads the dead-time counter.
    always_comb begin
        for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            case (state[i])
                CH_OFF: begin
                    if (cnt[i] != '0) begin
                        cnt_next[i] = cnt[i] - DEAD_TIME_WIDTH'(1);
                    end else if (target[i] != CH_OFF) begin
                        state_next[i] = target[i];
                    end
                end
                default: begin
                    if (target[i] != state[i]) begin
                        state_next[i] = CH_OFF;
                        cnt_next[i]   = dead_time;
                    end
                end
            endcase
        end
    end

    always_comb begin
        cnt_busy = 1'b0;
        for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
            driver_p[i] = (state[i] == CH_FWD);
            driver_n[i] = (state[i] == CH_REV);
            cnt_busy    = cnt_busy | (cnt[i] != '0);
        end
    end

    assign drivers_busy = (|driver_p) | (|driver_n) | cnt_busy;

endmodule
